// File: rtl/pifo_pkg.sv
// pifo_pkg: shared helpers for the pifo_sched scheduler queue (counter width, rank compare)
package pifo_pkg;
    localparam int MAX_RANK_W = 32;
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic logic rank_gt(input logic [MAX_RANK_W-1:0] a, input logic [MAX_RANK_W-1:0] b);
        return a > b;
    endfunction
endpackage

// File: rtl/pifo_slot.sv
// pifo_slot: one {rank, data} storage cell of the sorted shift array
module pifo_slot #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ins,
    input  logic         take_prev,
    input  logic         take_next,
    input  logic [W-1:0] new_e,
    input  logic [W-1:0] prev_e,
    input  logic [W-1:0] next_e,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        if (reset) q <= '0;
        else if (ins) q <= new_e;
        else if (take_prev) q <= prev_e;
        else if (take_next) q <= next_e;
endmodule

// File: rtl/pifo_sched.sv
// pifo_sched: sorted push-in-first-out scheduler queue, highest rank at head, FIFO among ties.
// Define PIFO_EVICT_EN to never back-pressure and instead evict the lowest-ranked entry when full.
module pifo_sched import pifo_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int RANK_W = 4,
    parameter int DATA_W = 16,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [RANK_W-1:0] push_rank,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [RANK_W-1:0] pop_rank,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
`ifdef PIFO_EVICT_EN
    ,
    output logic              evict_valid,
    output logic [RANK_W-1:0] evict_rank,
    output logic [DATA_W-1:0] evict_data
`endif
);
    localparam int W = RANK_W + DATA_W;
    logic [W-1:0] slot_q [DEPTH];
    logic [W-1:0] ext [DEPTH+2];
    logic [W-1:0] new_e;
    logic [DEPTH-1:0] gt, ins, take_prev, take_next;
    logic [CNT_W-1:0] cnt, cnt_n, pos, ip;
    logic empty_q, full_q, push_fire, pop_fire, discard;

`ifdef PIFO_EVICT_EN
    assign push_ready = 1'b1;
`else
    assign push_ready = !full_q || pop_ready;
`endif
    assign pop_valid = !empty_q;
    assign push_fire = push_valid && push_ready;
    assign pop_fire = pop_valid && pop_ready;
    assign new_e = {push_rank, push_data};
    assign {pop_rank, pop_data} = slot_q[0];
    assign count = cnt;
    assign empty = empty_q;
    assign full = full_q;

    // ext pads the array with zero entries so every slot has both neighbours
    always_comb begin
        ext[0] = '0;
        ext[DEPTH+1] = '0;
        for (int i = 0; i < DEPTH; i++) ext[i+1] = slot_q[i];
        pos = cnt;
        for (int i = DEPTH - 1; i >= 0; i--) if (gt[i]) pos = CNT_W'(i);
        ip = (pop_fire && pos != '0) ? pos - CNT_W'(1) : pos;
        discard = push_fire && !pop_fire && pos == CNT_W'(DEPTH);
        cnt_n = cnt + CNT_W'(push_fire && !pop_fire && !full_q) - CNT_W'(pop_fire && !push_fire);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign gt[g] = (CNT_W'(g) < cnt) &&
                       rank_gt(MAX_RANK_W'(push_rank), MAX_RANK_W'(slot_q[g][W-1:DATA_W]));
        assign ins[g] = push_fire && !discard && ip == CNT_W'(g);
        assign take_prev[g] = push_fire && !pop_fire && !discard && CNT_W'(g) > ip;
        assign take_next[g] = pop_fire && (!push_fire || CNT_W'(g) < ip);
        pifo_slot #(.W(W)) u_slot (
            .clk(clk), .reset(reset),
            .ins(ins[g]), .take_prev(take_prev[g]), .take_next(take_next[g]),
            .new_e(new_e), .prev_e(ext[g]), .next_e(ext[g+2]),
            .q(slot_q[g])
        );
    end

    always_ff @(posedge clk)
        if (reset) begin
            cnt <= '0;
            empty_q <= 1'b1;
            full_q <= 1'b0;
        end else begin
            cnt <= cnt_n;
            empty_q <= cnt_n == '0;
            full_q <= cnt_n == CNT_W'(DEPTH);
        end

`ifdef PIFO_EVICT_EN
    // when full, either the incoming entry or the old tail falls off the end
    always_ff @(posedge clk)
        if (reset) begin
            evict_valid <= 1'b0;
            evict_rank <= '0;
            evict_data <= '0;
        end else begin
            evict_valid <= push_fire && !pop_fire && full_q;
            {evict_rank, evict_data} <= discard ? new_e : slot_q[DEPTH-1];
        end
`endif
endmodule

// File: tb/tb_pifo_sched.sv
// tb_pifo_sched: directed and randomised checks of pifo_sched against a sorted queue model
module tb_pifo_sched;
    logic        clk = 0, reset = 1;
    logic        push_valid = 0, push_ready, pop_valid, pop_ready = 0, empty, full;
    logic [3:0]  push_rank = 0, pop_rank, count;
    logic [15:0] push_data = 0, pop_data;
`ifdef PIFO_EVICT_EN
    logic        evict_valid;
    logic [3:0]  evict_rank;
    logic [15:0] evict_data;
`endif
    int n_cmp = 0, n_bad = 0;

    pifo_sched #(.DEPTH(8), .RANK_W(4), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready), .push_rank(push_rank), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_rank(pop_rank), .pop_data(pop_data),
        .count(count), .empty(empty), .full(full)
`ifdef PIFO_EVICT_EN
        , .evict_valid(evict_valid), .evict_rank(evict_rank), .evict_data(evict_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic [15:0] d);
        push_valid = 1; push_rank = r; push_data = d;
        tick;
        push_valid = 0;
    endtask

    task automatic test_reset;
        reset = 1; push_valid = 1; push_rank = 5; push_data = 16'h1234;
        tick; tick;
        reset = 0; push_valid = 0;
        n_cmp++;
        if ({count, empty, full, pop_valid, pop_rank, pop_data, push_ready} !== {4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state got cnt=%0d e=%b f=%b pv=%b r=%0d d=%h pr=%b want cnt=0 e=1 f=0 pv=0 r=0 d=0000 pr=1",
                     count, empty, full, pop_valid, pop_rank, pop_data, push_ready);
        end
`ifdef PIFO_EVICT_EN
        n_cmp++;
        if (evict_valid !== 1'b0) begin n_bad++; $display("FAIL reset_evict got %b want 0", evict_valid); end
`endif
    endtask

    task automatic test_order;
        logic [3:0]  rk [4] = '{4'd3, 4'd9, 4'd1, 4'd9};
        logic [15:0] dt [4] = '{16'hA, 16'hB, 16'hC, 16'hD};
        logic [3:0]  er [4] = '{4'd9, 4'd9, 4'd3, 4'd1};
        logic [15:0] ed [4] = '{16'hB, 16'hD, 16'hA, 16'hC};
        for (int i = 0; i < 4; i++) push(rk[i], dt[i]);
        n_cmp++;
        if (count !== 4'd4) begin n_bad++; $display("FAIL order_count got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({pop_valid, pop_rank, pop_data} !== {1'b1, er[i], ed[i]}) begin
                n_bad++;
                $display("FAIL order_head[%0d] got v=%b %0d/%h want v=1 %0d/%h", i, pop_valid, pop_rank, pop_data, er[i], ed[i]);
            end
            pop_ready = 1; tick; pop_ready = 0;
        end
        n_cmp++;
        if ({empty, count} !== {1'b1, 4'd0}) begin n_bad++; $display("FAIL order_empty got e=%b cnt=%0d want e=1 cnt=0", empty, count); end
    endtask

    task automatic test_full;
        logic exp_pr;
        for (int i = 0; i < 8; i++) push(4'd5, 16'(i));
        n_cmp++;
        if ({full, count} !== {1'b1, 4'd8}) begin n_bad++; $display("FAIL full_flag got f=%b cnt=%0d want f=1 cnt=8", full, count); end
`ifdef PIFO_EVICT_EN
        exp_pr = 1'b1;
`else
        exp_pr = 1'b0;
`endif
        pop_ready = 0; #1;
        n_cmp++;
        if (push_ready !== exp_pr) begin n_bad++; $display("FAIL full_backpressure got %b want %b", push_ready, exp_pr); end
        push_valid = 1; push_rank = 7; push_data = 16'h77; pop_ready = 1; #1;
        n_cmp++;
        if ({push_ready, pop_rank} !== {1'b1, 4'd5}) begin n_bad++; $display("FAIL full_pushpop_pre got pr=%b r=%0d want pr=1 r=5", push_ready, pop_rank); end
        tick;
        push_valid = 0; pop_ready = 0;
        n_cmp++;
        if ({pop_rank, pop_data, count, full} !== {4'd7, 16'h77, 4'd8, 1'b1}) begin
            n_bad++;
            $display("FAIL full_pushpop got %0d/%h cnt=%0d f=%b want 7/0077 cnt=8 f=1", pop_rank, pop_data, count, full);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({pop_rank, pop_data} !== (i == 0 ? {4'd7, 16'h77} : {4'd5, 16'(i)})) begin
                n_bad++;
                $display("FAIL full_drain[%0d] got %0d/%h", i, pop_rank, pop_data);
            end
            pop_ready = 1; tick; pop_ready = 0;
        end
        n_cmp++;
        if (empty !== 1'b1) begin n_bad++; $display("FAIL full_drained got e=%b want 1", empty); end
    endtask

    task automatic test_empty_push;
        push_valid = 1; push_rank = 2; push_data = 16'h22; pop_ready = 1; #1;
        n_cmp++;
        if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL empty_push_nopop got pv=%b want 0", pop_valid); end
        tick;
        push_valid = 0;
        n_cmp++;
        if ({pop_valid, pop_rank, pop_data, count} !== {1'b1, 4'd2, 16'h22, 4'd1}) begin
            n_bad++;
            $display("FAIL empty_push_head got v=%b %0d/%h cnt=%0d want v=1 2/0022 cnt=1", pop_valid, pop_rank, pop_data, count);
        end
        tick;
        pop_ready = 0;
        n_cmp++;
        if (empty !== 1'b1) begin n_bad++; $display("FAIL empty_push_pop got e=%b want 1", empty); end
    endtask

    task automatic test_reset_mid;
        for (int i = 1; i <= 5; i++) push(4'(i), 16'(i));
        n_cmp++;
        if (count !== 4'd5) begin n_bad++; $display("FAIL rstmid_fill got %0d want 5", count); end
        reset = 1; push_valid = 1; push_rank = 9; push_data = 16'h99;
        tick;
        reset = 0; push_valid = 0;
        n_cmp++;
        if ({count, empty, pop_valid, pop_rank} !== {4'd0, 1'b1, 1'b0, 4'd0}) begin
            n_bad++;
            $display("FAIL rstmid_clear got cnt=%0d e=%b pv=%b r=%0d want cnt=0 e=1 pv=0 r=0", count, empty, pop_valid, pop_rank);
        end
        tick;
        n_cmp++;
        if (empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_push_ignored got e=%b want 1", empty); end
    endtask

`ifdef PIFO_EVICT_EN
    task automatic test_evict;
        logic [3:0]  er [8] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd4, 4'd3, 4'd2};
        logic [15:0] ed [8] = '{16'h108, 16'h107, 16'h106, 16'h105, 16'h104, 16'h44, 16'h103, 16'h102};
        for (int i = 8; i >= 1; i--) push(4'(i), 16'h100 + 16'(i));
        push(4'd4, 16'h44);
        n_cmp++;
        if ({evict_valid, evict_rank, evict_data, count} !== {1'b1, 4'd1, 16'h101, 4'd8}) begin
            n_bad++;
            $display("FAIL evict_tail got v=%b %0d/%h cnt=%0d want v=1 1/0101 cnt=8", evict_valid, evict_rank, evict_data, count);
        end
        push(4'd0, 16'h55);
        n_cmp++;
        if ({evict_valid, evict_rank, evict_data} !== {1'b1, 4'd0, 16'h55}) begin
            n_bad++;
            $display("FAIL evict_incoming got v=%b %0d/%h want v=1 0/0055", evict_valid, evict_rank, evict_data);
        end
        tick;
        n_cmp++;
        if (evict_valid !== 1'b0) begin n_bad++; $display("FAIL evict_pulse got %b want 0", evict_valid); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({pop_rank, pop_data} !== {er[i], ed[i]}) begin
                n_bad++;
                $display("FAIL evict_drain[%0d] got %0d/%h want %0d/%h", i, pop_rank, pop_data, er[i], ed[i]);
            end
            pop_ready = 1; tick; pop_ready = 0;
        end
    endtask
`endif

    task automatic test_random;
        logic [3:0]  mr [$];
        logic [15:0] md [$];
        logic exp_pr, pop_f, push_f;
        int idx;
        for (int c = 0; c < 10000; c++) begin
            push_valid = $urandom_range(0, 9) < 6;
            push_rank = 4'($urandom_range(0, 7));
            push_data = 16'(c);
            pop_ready = $urandom_range(0, 1) == 1;
`ifdef PIFO_EVICT_EN
            exp_pr = 1'b1;
`else
            exp_pr = mr.size() < 8 || pop_ready;
`endif
            #1;
            n_cmp++;
            if (push_ready !== exp_pr) begin n_bad++; $display("FAIL rand_push_ready[%0d] got %b want %b", c, push_ready, exp_pr); end
            pop_f = mr.size() > 0 && pop_ready;
            push_f = push_valid && exp_pr;
            if (pop_f) begin void'(mr.pop_front()); void'(md.pop_front()); end
            if (push_f) begin
                if (mr.size() == 8 && push_rank > mr[7]) begin void'(mr.pop_back()); void'(md.pop_back()); end
                if (mr.size() < 8) begin
                    idx = mr.size();
                    for (int j = mr.size() - 1; j >= 0; j--) if (mr[j] < push_rank) idx = j;
                    mr.insert(idx, push_rank);
                    md.insert(idx, push_data);
                end
            end
            tick;
            n_cmp++;
            if (count !== 4'(mr.size()) || count > 4'd8 || pop_valid !== (mr.size() > 0) ||
                (mr.size() > 0 && {pop_rank, pop_data} !== {mr[0], md[0]})) begin
                n_bad++;
                $display("FAIL rand_state[%0d] got cnt=%0d v=%b %0d/%h want cnt=%0d head=%0d/%h", c, count, pop_valid,
                         pop_rank, pop_data, mr.size(), mr.size() > 0 ? mr[0] : 4'd0, mr.size() > 0 ? md[0] : 16'd0);
            end
        end
        push_valid = 0; pop_ready = 0;
    endtask

    initial begin
        test_reset;
        test_order;
        test_full;
        test_empty_push;
        test_reset_mid;
`ifdef PIFO_EVICT_EN
        test_evict;
        test_reset;
`endif
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
